// File: rtl/memory_arbiter_pkg.sv
// Shared constants for the two-master memory arbiter: access option
// encodings (funct3), FSM state codes and master identifiers.
package memory_arbiter_pkg;

    // Load option encodings
    localparam logic [2:0] OPT_LB  = 3'b000;
    localparam logic [2:0] OPT_LH  = 3'b001;
    localparam logic [2:0] OPT_LW  = 3'b010;
    localparam logic [2:0] OPT_LBU = 3'b100;
    localparam logic [2:0] OPT_LHU = 3'b101;
    // Store option encodings reuse the load size codes
    localparam logic [2:0] OPT_SB  = 3'b000;
    localparam logic [2:0] OPT_SH  = 3'b001;
    localparam logic [2:0] OPT_SW  = 3'b010;

    // FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Master identifiers (grant index)
    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin grant, purely combinational.
//   req        in   2  pending request per master
//   last_grant in   1  master served most recently
//   grant_c    out  1  index of the winning master
//   valid_c    out  1  at least one request pending
module memory_arbiter_rr
    import memory_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_c,
    output logic       valid_c
);

    // On a tie the master not served last wins
    always_comb begin
        valid_c = |req;
        grant_c = MASTER_0;
        if (req == 2'b11) begin
            grant_c = ~last_grant;
        end else if (req[1]) begin
            grant_c = MASTER_1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between master 0 (core) and master 1 (loader).
// One request is latched in IDLE, a single strobe is issued, the read
// latency is waited out, then a one-cycle response is returned.
//   clk, reset                 clock, async active-high reset
//   mX_memory_read/_write      level requests, held until response
//   mX_option/_address/_write_data   request payload
//   mX_read_data               registered load data per master
//   mX_memory_response         one-cycle completion pulse
//   mem_memory_read/_write     memory strobes (ISSUE cycle only)
//   mem_option/_address/_write_data  latched payload toward memory
//   mem_read_data              load data from memory
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_memory_read,
    input  logic                  m0_memory_write,
    input  logic [2:0]            m0_option,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_memory_response,
    input  logic                  m1_memory_read,
    input  logic                  m1_memory_write,
    input  logic [2:0]            m1_option,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_memory_response,
    output logic                  mem_memory_read,
    output logic                  mem_memory_write,
    output logic [2:0]            mem_option,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    // Counter holds the remaining WAIT cycles, at most MEM_LATENCY-2
    localparam int unsigned CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

    state_t                state_q, state_d;
    logic                  lat_write_q, lat_write_d;
    logic                  lat_master_q, lat_master_d;
    logic [2:0]            lat_option_q, lat_option_d;
    logic [ADDR_WIDTH-1:0] lat_address_q, lat_address_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;
    logic                  rd_strobe_d, wr_strobe_d, resp0_d, resp1_d;
    logic                  arb_grant_c, arb_valid_c;

    memory_arbiter_rr u_rr (
        .req        ({m1_memory_read | m1_memory_write, m0_memory_read | m0_memory_write}),
        .last_grant (last_grant_q),
        .grant_c    (arb_grant_c),
        .valid_c    (arb_valid_c)
    );

    // Payload toward memory comes straight from the latch registers
    assign mem_option     = lat_option_q;
    assign mem_address    = lat_address_q;
    assign mem_write_data = lat_wdata_q;

    // Next-state, latch and registered-output logic
    always_comb begin
        state_d       = state_q;
        lat_write_d   = lat_write_q;
        lat_master_d  = lat_master_q;
        lat_option_d  = lat_option_q;
        lat_address_d = lat_address_q;
        lat_wdata_d   = lat_wdata_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        rdata0_d      = m0_read_data;
        rdata1_d      = m1_read_data;
        rd_strobe_d   = 1'b0;
        wr_strobe_d   = 1'b0;
        resp0_d       = 1'b0;
        resp1_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    state_d      = ST_ISSUE;
                    lat_master_d = arb_grant_c;
                    // Write takes precedence when both read and write are raised
                    if (arb_grant_c == MASTER_1) begin
                        lat_write_d   = m1_memory_write;
                        lat_option_d  = m1_option;
                        lat_address_d = m1_address;
                        lat_wdata_d   = m1_write_data;
                    end else begin
                        lat_write_d   = m0_memory_write;
                        lat_option_d  = m0_option;
                        lat_address_d = m0_address;
                        lat_wdata_d   = m0_write_data;
                    end
                    wr_strobe_d = lat_write_d;
                    rd_strobe_d = ~lat_write_d;
                end
            end
            ST_ISSUE: begin
                if (MEM_LATENCY <= 1) begin
                    state_d = ST_DONE;
                    resp0_d = (lat_master_q == MASTER_0);
                    resp1_d = (lat_master_q == MASTER_1);
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LATENCY - 2);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    resp0_d = (lat_master_q == MASTER_0);
                    resp1_d = (lat_master_q == MASTER_1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                last_grant_d = lat_master_q;
                if (!lat_write_q) begin
                    if (lat_master_q == MASTER_0) begin
                        rdata0_d = mem_read_data;
                    end else begin
                        rdata1_d = mem_read_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; last_grant resets to master 1 so master 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            lat_write_q        <= 1'b0;
            lat_master_q       <= MASTER_0;
            lat_option_q       <= '0;
            lat_address_q      <= '0;
            lat_wdata_q        <= '0;
            cnt_q              <= '0;
            last_grant_q       <= MASTER_1;
            m0_read_data       <= '0;
            m1_read_data       <= '0;
            mem_memory_read    <= 1'b0;
            mem_memory_write   <= 1'b0;
            m0_memory_response <= 1'b0;
            m1_memory_response <= 1'b0;
        end else begin
            state_q            <= state_d;
            lat_write_q        <= lat_write_d;
            lat_master_q       <= lat_master_d;
            lat_option_q       <= lat_option_d;
            lat_address_q      <= lat_address_d;
            lat_wdata_q        <= lat_wdata_d;
            cnt_q              <= cnt_d;
            last_grant_q       <= last_grant_d;
            m0_read_data       <= rdata0_d;
            m1_read_data       <= rdata1_d;
            mem_memory_read    <= rd_strobe_d;
            mem_memory_write   <= wr_strobe_d;
            m0_memory_response <= resp0_d;
            m1_memory_response <= resp1_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a MEM_LATENCY=1 instance (f_*) and a
// MEM_LATENCY=3 instance (s_*) share the same master-side stimulus.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_memory_read = 1'b0, m0_memory_write = 1'b0;
    logic [2:0]  m0_option = 3'b0;
    logic [31:0] m0_address = '0, m0_write_data = '0;
    logic        m1_memory_read = 1'b0, m1_memory_write = 1'b0;
    logic [2:0]  m1_option = 3'b0;
    logic [31:0] m1_address = '0, m1_write_data = '0;
    logic [31:0] mem_read_data = '0;

    logic [31:0] f_m0_read_data, f_m1_read_data, f_mem_address, f_mem_write_data;
    logic        f_m0_resp, f_m1_resp, f_mem_read, f_mem_write;
    logic [2:0]  f_mem_option;
    logic [31:0] s_m0_read_data, s_m1_read_data, s_mem_address, s_mem_write_data;
    logic        s_m0_resp, s_m1_resp, s_mem_read, s_mem_write;
    logic [2:0]  s_mem_option;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_fast (
        .clk(clk), .reset(reset),
        .m0_memory_read(m0_memory_read), .m0_memory_write(m0_memory_write),
        .m0_option(m0_option), .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_read_data(f_m0_read_data), .m0_memory_response(f_m0_resp),
        .m1_memory_read(m1_memory_read), .m1_memory_write(m1_memory_write),
        .m1_option(m1_option), .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_read_data(f_m1_read_data), .m1_memory_response(f_m1_resp),
        .mem_memory_read(f_mem_read), .mem_memory_write(f_mem_write),
        .mem_option(f_mem_option), .mem_address(f_mem_address),
        .mem_write_data(f_mem_write_data), .mem_read_data(mem_read_data)
    );

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_slow (
        .clk(clk), .reset(reset),
        .m0_memory_read(m0_memory_read), .m0_memory_write(m0_memory_write),
        .m0_option(m0_option), .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_read_data(s_m0_read_data), .m0_memory_response(s_m0_resp),
        .m1_memory_read(m1_memory_read), .m1_memory_write(m1_memory_write),
        .m1_option(m1_option), .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_read_data(s_m1_read_data), .m1_memory_response(s_m1_resp),
        .mem_memory_read(s_mem_read), .mem_memory_write(s_mem_write),
        .mem_option(s_mem_option), .mem_address(s_mem_address),
        .mem_write_data(s_mem_write_data), .mem_read_data(mem_read_data)
    );

    // Step one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        m0_memory_read = 1'b0; m0_memory_write = 1'b0; m0_option = 3'b0;
        m0_address = '0; m0_write_data = '0;
        m1_memory_read = 1'b0; m1_memory_write = 1'b0; m1_option = 3'b0;
        m1_address = '0; m1_write_data = '0;
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        logic [107:0] f_all, s_all;
        do_reset;
        f_all = {f_m0_read_data, f_m1_read_data, f_mem_address, f_m0_resp, f_m1_resp,
                 f_mem_read, f_mem_write, f_mem_option, f_mem_write_data[0]};
        s_all = {s_m0_read_data, s_m1_read_data, s_mem_address, s_m0_resp, s_m1_resp,
                 s_mem_read, s_mem_write, s_mem_option, s_mem_write_data[0]};
        checks++; if (f_all !== '0 || f_mem_write_data !== '0) begin errors++; $display("FAIL reset_fast got %h want 0", f_all); end
        checks++; if (s_all !== '0 || s_mem_write_data !== '0) begin errors++; $display("FAIL reset_slow got %h want 0", s_all); end
        tick;
        checks++; if ({f_mem_read, f_mem_write} !== 2'b00) begin errors++; $display("FAIL idle_quiet got %b want 00", {f_mem_read, f_mem_write}); end
    endtask

    task automatic test_single_read;
        do_reset;
        m0_memory_read = 1'b1; m0_option = OPT_LW; m0_address = 32'h10;
        mem_read_data = 32'hDEAD_BEEF;
        checks++; if (f_mem_read !== 1'b0) begin errors++; $display("FAIL t1_early_strobe got %b want 0", f_mem_read); end
        tick;
        checks++; if ({f_mem_read, f_mem_write} !== 2'b10) begin errors++; $display("FAIL t1_strobe got %b want 10", {f_mem_read, f_mem_write}); end
        checks++; if (f_mem_address !== 32'h10) begin errors++; $display("FAIL t1_addr got %h want 10", f_mem_address); end
        checks++; if (f_mem_option !== 3'b010) begin errors++; $display("FAIL t1_option got %b want 010", f_mem_option); end
        checks++; if (f_m0_resp !== 1'b0) begin errors++; $display("FAIL t1_resp_early got %b want 0", f_m0_resp); end
        tick;
        checks++; if ({f_m0_resp, f_m1_resp, f_mem_read} !== 3'b100) begin errors++; $display("FAIL t1_resp got %b want 100", {f_m0_resp, f_m1_resp, f_mem_read}); end
        m0_memory_read = 1'b0;
        tick;
        checks++; if (f_m0_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata got %h want deadbeef", f_m0_read_data); end
        checks++; if ({f_m1_read_data, f_m0_resp, f_m1_resp} !== 34'h0) begin errors++; $display("FAIL t1_m1_quiet got %h want 0", {f_m1_read_data, f_m0_resp, f_m1_resp}); end
        tick;
        checks++; if (f_mem_read !== 1'b0) begin errors++; $display("FAIL t1_no_reissue got %b want 0", f_mem_read); end
    endtask

    task automatic test_round_robin;
        do_reset;
        m0_memory_read = 1'b1; m0_address = 32'h100; m0_option = OPT_LW;
        m1_memory_read = 1'b1; m1_address = 32'h200; m1_option = OPT_LW;
        mem_read_data = 32'hAAAA_0001;
        tick;
        checks++; if (f_mem_address !== 32'h100) begin errors++; $display("FAIL rr_first got %h want 100", f_mem_address); end
        tick;
        checks++; if ({f_m0_resp, f_m1_resp} !== 2'b10) begin errors++; $display("FAIL rr_resp0 got %b want 10", {f_m0_resp, f_m1_resp}); end
        m0_memory_read = 1'b0;
        tick;
        checks++; if (f_m0_read_data !== 32'hAAAA_0001) begin errors++; $display("FAIL rr_rdata0 got %h want aaaa0001", f_m0_read_data); end
        mem_read_data = 32'hBBBB_0002;
        tick;
        checks++; if ({f_mem_read, f_mem_address} !== {1'b1, 32'h200}) begin errors++; $display("FAIL rr_second got %b/%h want 1/200", f_mem_read, f_mem_address); end
        tick;
        checks++; if ({f_m0_resp, f_m1_resp} !== 2'b01) begin errors++; $display("FAIL rr_resp1 got %b want 01", {f_m0_resp, f_m1_resp}); end
        m1_memory_read = 1'b0;
        tick;
        checks++; if ({f_m1_read_data, f_m0_read_data} !== {32'hBBBB_0002, 32'hAAAA_0001}) begin errors++; $display("FAIL rr_rdata1 got %h/%h want bbbb0002/aaaa0001", f_m1_read_data, f_m0_read_data); end
        // Both again after m1 was last: m0 first
        m0_memory_read = 1'b1; m1_memory_read = 1'b1;
        tick;
        checks++; if (f_mem_address !== 32'h100) begin errors++; $display("FAIL rr_again got %h want 100", f_mem_address); end
        tick;
        m0_memory_read = 1'b0;
        tick; tick;
        checks++; if (f_mem_address !== 32'h200) begin errors++; $display("FAIL rr_again2 got %h want 200", f_mem_address); end
        tick;
        m1_memory_read = 1'b0;
        tick;
        // m0 alone, then both: m1 must win the tie
        m0_memory_read = 1'b1;
        tick; tick;
        m0_memory_read = 1'b0;
        tick;
        m0_memory_read = 1'b1; m1_memory_read = 1'b1;
        tick;
        checks++; if (f_mem_address !== 32'h200) begin errors++; $display("FAIL rr_m1_first got %h want 200", f_mem_address); end
        tick;
        checks++; if ({f_m0_resp, f_m1_resp} !== 2'b01) begin errors++; $display("FAIL rr_m1_resp got %b want 01", {f_m0_resp, f_m1_resp}); end
        m1_memory_read = 1'b0;
        tick; tick;
        checks++; if (f_mem_address !== 32'h100) begin errors++; $display("FAIL rr_m0_after got %h want 100", f_mem_address); end
        tick;
        m0_memory_read = 1'b0;
        tick;
    endtask

    task automatic test_write_priority;
        // m1_read_data holds bbbb0002 from the previous scenario
        mem_read_data = 32'hCAFE_F00D;
        m1_memory_read = 1'b1; m1_memory_write = 1'b1; m1_option = OPT_SW;
        m1_address = 32'h20; m1_write_data = 32'h1234_5678;
        tick;
        checks++; if ({f_mem_read, f_mem_write} !== 2'b01) begin errors++; $display("FAIL wr_strobe got %b want 01", {f_mem_read, f_mem_write}); end
        checks++; if ({f_mem_option, f_mem_address, f_mem_write_data} !== {3'b010, 32'h20, 32'h1234_5678}) begin errors++; $display("FAIL wr_payload got %b/%h/%h want 010/20/12345678", f_mem_option, f_mem_address, f_mem_write_data); end
        m1_address = 32'h24; m1_write_data = 32'h0;
        tick;
        checks++; if ({f_m1_resp, f_mem_address} !== {1'b1, 32'h20}) begin errors++; $display("FAIL wr_resp got %b/%h want 1/20", f_m1_resp, f_mem_address); end
        m1_memory_read = 1'b0; m1_memory_write = 1'b0;
        tick;
        checks++; if (f_m1_read_data !== 32'hBBBB_0002) begin errors++; $display("FAIL wr_rdata_kept got %h want bbbb0002", f_m1_read_data); end
    endtask

    task automatic test_long_latency;
        do_reset;
        m0_memory_read = 1'b1; m0_option = OPT_LW; m0_address = 32'h40;
        mem_read_data = 32'h0BAD_F00D;
        tick;
        checks++; if ({s_mem_read, s_mem_address} !== {1'b1, 32'h40}) begin errors++; $display("FAIL lat_strobe got %b/%h want 1/40", s_mem_read, s_mem_address); end
        m0_address = 32'h44;
        tick;
        checks++; if ({s_mem_read, s_m0_resp, s_mem_address} !== {2'b00, 32'h40}) begin errors++; $display("FAIL lat_wait1 got %b%b/%h want 00/40", s_mem_read, s_m0_resp, s_mem_address); end
        tick;
        checks++; if (s_m0_resp !== 1'b0) begin errors++; $display("FAIL lat_wait2 got %b want 0", s_m0_resp); end
        tick;
        checks++; if (s_m0_resp !== 1'b1) begin errors++; $display("FAIL lat_resp got %b want 1", s_m0_resp); end
        m0_memory_read = 1'b0;
        tick;
        checks++; if ({s_m0_resp, s_m0_read_data} !== {1'b0, 32'h0BAD_F00D}) begin errors++; $display("FAIL lat_rdata got %b/%h want 0/0badf00d", s_m0_resp, s_m0_read_data); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        m0_memory_read = 1'b1; m0_option = OPT_LW; m0_address = 32'h80;
        mem_read_data = 32'h7777_8888;
        tick;
        checks++; if (s_mem_read !== 1'b1) begin errors++; $display("FAIL rst_strobe got %b want 1", s_mem_read); end
        tick;
        checks++; if (s_mem_address !== 32'h80) begin errors++; $display("FAIL rst_wait_addr got %h want 80", s_mem_address); end
        reset = 1'b1;
        #1;
        checks++; if ({s_mem_read, s_mem_write, s_m0_resp, s_m1_resp, s_mem_address} !== 36'h0) begin errors++; $display("FAIL rst_async got %h want 0", {s_mem_read, s_mem_write, s_m0_resp, s_m1_resp, s_mem_address}); end
        m0_memory_read = 1'b0;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (s_m0_resp !== 1'b0) begin errors++; $display("FAIL rst_no_resp got %b want 0", s_m0_resp); end
        end
        m0_memory_read = 1'b1; m0_address = 32'h84;
        mem_read_data = 32'h5555_AAAA;
        tick;
        checks++; if ({s_mem_read, s_mem_address} !== {1'b1, 32'h84}) begin errors++; $display("FAIL rst_reissue got %b/%h want 1/84", s_mem_read, s_mem_address); end
        tick; tick; tick;
        checks++; if (s_m0_resp !== 1'b1) begin errors++; $display("FAIL rst_resp got %b want 1", s_m0_resp); end
        m0_memory_read = 1'b0;
        tick;
        checks++; if (s_m0_read_data !== 32'h5555_AAAA) begin errors++; $display("FAIL rst_rdata got %h want 5555aaaa", s_m0_read_data); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        m0_memory_read = 1'b1; m0_option = OPT_LW; m0_address = 32'h30;
        mem_read_data = 32'h1111_2222;
        tick;
        tick;
        checks++; if (f_m0_resp !== 1'b1) begin errors++; $display("FAIL b2b_resp1 got %b want 1", f_m0_resp); end
        tick;
        checks++; if ({f_m0_resp, f_mem_read, f_m0_read_data} !== {2'b00, 32'h1111_2222}) begin errors++; $display("FAIL b2b_idle got %b%b/%h want 00/11112222", f_m0_resp, f_mem_read, f_m0_read_data); end
        tick;
        checks++; if (f_mem_read !== 1'b1) begin errors++; $display("FAIL b2b_strobe2 got %b want 1", f_mem_read); end
        mem_read_data = 32'h3333_4444;
        m0_memory_read = 1'b0;
        tick;
        checks++; if (f_m0_resp !== 1'b1) begin errors++; $display("FAIL b2b_resp2 got %b want 1", f_m0_resp); end
        tick;
        checks++; if ({f_m0_resp, f_m0_read_data} !== {1'b0, 32'h3333_4444}) begin errors++; $display("FAIL b2b_rdata2 got %b/%h want 0/33334444", f_m0_resp, f_m0_read_data); end
        tick;
        checks++; if (f_mem_read !== 1'b0) begin errors++; $display("FAIL b2b_no_third got %b want 0", f_mem_read); end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_round_robin;
        test_write_priority;
        test_long_latency;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
